// File: rtl/sdram_fifo_ctrl.sv
// sdram_fifo_ctrl: buffered user front end for sdram_ctrl.
// A write FIFO feeds fixed-length write bursts and a read FIFO collects the words
// returned by read bursts; both burst addresses auto-increment and wrap.
// Optional feature macro: SDRAM_FIFO_CTRL_FLUSH_EN adds flush_i, which clears both
// FIFOs and resets both addresses on an IDLE cycle.
module sdram_fifo_ctrl #(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter logic [23:0] WR_BASE    = 24'h000000,
  parameter logic [23:0] WR_END     = 24'h0003FF,
  parameter logic [23:0] RD_BASE    = 24'h000000,
  parameter logic [23:0] RD_END     = 24'h0003FF
) (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
`ifdef SDRAM_FIFO_CTRL_FLUSH_EN
  input  logic        flush_i,
`endif
  input  logic        wr_en_i,
  input  logic [15:0] wr_data_i,
  output logic        wr_full_o,
  input  logic        rd_en_i,
  output logic [15:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        rd_empty_o,
  input  logic        rd_allow_i,
  input  logic        sdram_init_end_i,
  output logic        sdram_wr_req_o,
  output logic [23:0] sdram_wr_addr_o,
  output logic [15:0] sdram_wr_data_o,
  output logic [9:0]  sdram_wr_length_o,
  input  logic        sdram_wr_ack_i,
  output logic        sdram_rd_req_o,
  output logic [23:0] sdram_rd_addr_o,
  output logic [9:0]  sdram_rd_length_o,
  input  logic [15:0] sdram_rd_data_i,
  input  logic        sdram_rd_ack_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] BURST_L = LW'(BURST_LEN);
  localparam logic [9:0]    LAST_CNT = 10'(BURST_LEN - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]    r_state, w_state_d;
  logic [9:0]    r_cnt, w_cnt_d;
  logic [23:0]   r_wr_addr, r_rd_addr;
  logic [15:0]   r_wr_mem [FIFO_DEPTH];
  logic [15:0]   r_rd_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_wptr, r_wr_rptr, r_rd_wptr, r_rd_rptr;
  logic [LW-1:0] r_wr_level, r_rd_level, w_wr_level_d, w_rd_level_d;
  logic          r_wr_full, r_rd_empty;
  logic [15:0]   r_rd_data;
  logic          r_rd_valid;

  logic          w_flush;
  logic          w_wr_push, w_wr_pop, w_rd_push, w_rd_pop, w_last;
  logic [LW-1:0] w_rd_free;
  logic [24:0]   w_wr_sum, w_rd_sum;
  logic [23:0]   w_wr_addr_nxt, w_rd_addr_nxt;

`ifdef SDRAM_FIFO_CTRL_FLUSH_EN
  logic r_flush_pend;

  // Hold a flush requested mid-burst until the FSM is back in IDLE.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     r_flush_pend <= 1'b0;
    else if (w_flush) r_flush_pend <= 1'b0;
    else if (flush_i) r_flush_pend <= 1'b1;
  end

  assign w_flush = (r_state == ST_IDLE) && (flush_i || r_flush_pend);
`else
  assign w_flush = 1'b0;
`endif

  // Acks only count in their own burst state; FIFO pushes/pops otherwise come from the user.
  assign w_wr_push = wr_en_i && !r_wr_full;
  assign w_wr_pop  = (r_state == ST_WR) && sdram_wr_ack_i;
  assign w_rd_push = (r_state == ST_RD) && sdram_rd_ack_i;
  assign w_rd_pop  = rd_en_i && !r_rd_empty && !w_flush;
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_rd_free = DEPTH_L - r_rd_level;

  // Next burst addresses, wrapping to BASE once past END.
  always_comb begin
    w_wr_sum      = {1'b0, r_wr_addr} + 25'(BURST_LEN);
    w_rd_sum      = {1'b0, r_rd_addr} + 25'(BURST_LEN);
    w_wr_addr_nxt = (w_wr_sum > {1'b0, WR_END}) ? WR_BASE : w_wr_sum[23:0];
    w_rd_addr_nxt = (w_rd_sum > {1'b0, RD_END}) ? RD_BASE : w_rd_sum[23:0];
  end

  // Next FIFO levels; a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    w_wr_level_d = r_wr_level;
    if (w_wr_push && !w_wr_pop)      w_wr_level_d = r_wr_level + LW'(1);
    else if (!w_wr_push && w_wr_pop) w_wr_level_d = r_wr_level - LW'(1);
    w_rd_level_d = r_rd_level;
    if (w_rd_push && !w_rd_pop)      w_rd_level_d = r_rd_level + LW'(1);
    else if (!w_rd_push && w_rd_pop) w_rd_level_d = r_rd_level - LW'(1);
  end

  // Burst FSM next state; writes win over reads, GAP forces a req-low cycle.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (sdram_init_end_i && !w_flush) begin
          if (r_wr_level >= BURST_L)                     w_state_d = ST_WR;
          else if (rd_allow_i && (w_rd_free >= BURST_L)) w_state_d = ST_RD;
        end
      end
      ST_WR: begin
        if (sdram_wr_ack_i) begin
          if (w_last) begin
            w_state_d = ST_GAP;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 10'd1;
          end
        end
      end
      ST_RD: begin
        if (sdram_rd_ack_i) begin
          if (w_last) begin
            w_state_d = ST_GAP;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 10'd1;
          end
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  // FSM state and ack counter.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Burst addresses advance on the final ack of a burst.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_addr <= WR_BASE;
      r_rd_addr <= RD_BASE;
    end else if (w_flush) begin
      r_wr_addr <= WR_BASE;
      r_rd_addr <= RD_BASE;
    end else begin
      if (w_wr_pop && w_last) r_wr_addr <= w_wr_addr_nxt;
      if (w_rd_push && w_last) r_rd_addr <= w_rd_addr_nxt;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge sys_clk_i) begin
    if (w_wr_push) r_wr_mem[r_wr_wptr] <= wr_data_i;
    if (w_rd_push) r_rd_mem[r_rd_wptr] <= sdram_rd_data_i;
  end

  // Write FIFO pointers, level and registered full flag.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_wptr  <= '0;
      r_wr_rptr  <= '0;
      r_wr_level <= '0;
      r_wr_full  <= 1'b0;
    end else if (w_flush) begin
      r_wr_wptr  <= '0;
      r_wr_rptr  <= '0;
      r_wr_level <= '0;
      r_wr_full  <= 1'b0;
    end else begin
      if (w_wr_push) r_wr_wptr <= r_wr_wptr + AW'(1);
      if (w_wr_pop)  r_wr_rptr <= r_wr_rptr + AW'(1);
      r_wr_level <= w_wr_level_d;
      r_wr_full  <= (w_wr_level_d == DEPTH_L);
    end
  end

  // Read FIFO pointers, level, empty flag and registered user output.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_wptr  <= '0;
      r_rd_rptr  <= '0;
      r_rd_level <= '0;
      r_rd_empty <= 1'b1;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_flush) begin
      r_rd_wptr  <= '0;
      r_rd_rptr  <= '0;
      r_rd_level <= '0;
      r_rd_empty <= 1'b1;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_rd_push) r_rd_wptr <= r_rd_wptr + AW'(1);
      if (w_rd_pop) begin
        r_rd_rptr <= r_rd_rptr + AW'(1);
        r_rd_data <= r_rd_mem[r_rd_rptr];
      end
      r_rd_valid <= w_rd_pop;
      r_rd_level <= w_rd_level_d;
      r_rd_empty <= (w_rd_level_d == '0);
    end
  end

  assign wr_full_o         = r_wr_full;
  assign rd_empty_o        = r_rd_empty;
  assign rd_data_o         = r_rd_data;
  assign rd_valid_o        = r_rd_valid;
  assign sdram_wr_req_o    = (r_state == ST_WR);
  assign sdram_rd_req_o    = (r_state == ST_RD);
  assign sdram_wr_addr_o   = r_wr_addr;
  assign sdram_rd_addr_o   = r_rd_addr;
  assign sdram_wr_data_o   = r_wr_mem[r_wr_rptr];
  assign sdram_wr_length_o = 10'(BURST_LEN);
  assign sdram_rd_length_o = 10'(BURST_LEN);

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Directed bench for sdram_fifo_ctrl with a small FIFO and a 16-word write window.
module tb_sdram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        wr_full;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_empty;
  logic        rd_allow;
  logic        init_end;
  logic        wr_req;
  logic [23:0] wr_addr;
  logic [15:0] wr_dout;
  logic [9:0]  wr_len;
  logic        wr_ack;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic [9:0]  rd_len;
  logic [15:0] rd_din;
  logic        rd_ack;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdram_fifo_ctrl #(
    .BURST_LEN (8),
    .FIFO_DEPTH(16),
    .WR_BASE   (24'h000000),
    .WR_END    (24'h00000F),
    .RD_BASE   (24'h000000),
    .RD_END    (24'h0003FF)
  ) dut (
    .sys_clk_i        (clk),
    .rst_n_i          (rst_n),
    .wr_en_i          (wr_en),
    .wr_data_i        (wr_data),
    .wr_full_o        (wr_full),
    .rd_en_i          (rd_en),
    .rd_data_o        (rd_data),
    .rd_valid_o       (rd_valid),
    .rd_empty_o       (rd_empty),
    .rd_allow_i       (rd_allow),
    .sdram_init_end_i (init_end),
    .sdram_wr_req_o   (wr_req),
    .sdram_wr_addr_o  (wr_addr),
    .sdram_wr_data_o  (wr_dout),
    .sdram_wr_length_o(wr_len),
    .sdram_wr_ack_i   (wr_ack),
    .sdram_rd_req_o   (rd_req),
    .sdram_rd_addr_o  (rd_addr),
    .sdram_rd_length_o(rd_len),
    .sdram_rd_data_i  (rd_din),
    .sdram_rd_ack_i   (rd_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Waits (bounded) for a write burst, then acks 8 words back to back.
  task automatic wr_burst(input logic [23:0] a, input logic [15:0] d0);
    int n = 0;
    while (wr_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("wr_req_rise", 32'(wr_req), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("wr_addr", 32'(wr_addr), 32'(a));
      chk("wr_data", 32'(wr_dout), 32'(d0 + 16'(i)));
      wr_ack = 1'b1;
      tick();
    end
    wr_ack = 1'b0;
    chk("wr_req_fall", 32'(wr_req), 32'd0);
  endtask

  // Acks 8 read words d0..d0+7 into the read FIFO.
  task automatic rd_burst(input logic [23:0] a, input logic [15:0] d0);
    int n = 0;
    while (rd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("rd_req_rise", 32'(rd_req), 32'd1);
    chk("rd_addr", 32'(rd_addr), 32'(a));
    for (int i = 0; i < 8; i++) begin
      rd_ack = 1'b1;
      rd_din = d0 + 16'(i);
      tick();
    end
    rd_ack = 1'b0;
    chk("rd_req_fall", 32'(rd_req), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; rd_allow = 1'b0;
    init_end = 1'b0; wr_ack = 1'b0; rd_din = '0; rd_ack = 1'b0;
    tick(); tick();
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_full", 32'(wr_full), 32'd0);
    chk("rst_rd_empty", 32'(rd_empty), 32'd1);
    chk("wr_len", 32'(wr_len), 32'd8);
    chk("rd_len", 32'(rd_len), 32'd8);
    rst_n = 1'b1;
    tick();

    // Overflow: 17 pushes into a 16-deep FIFO before init completes.
    for (int i = 0; i < 17; i++) push(16'h0100 + 16'(i));
    chk("ovf_full", 32'(wr_full), 32'd1);
    chk("ovf_no_req", 32'(wr_req), 32'd0);

    // Drain as two bursts; the 17th word must be absent.
    init_end = 1'b1;
    wr_burst(24'h000000, 16'h0100);
    chk("full_clear", 32'(wr_full), 32'd0);
    wr_burst(24'h000008, 16'h0108);
    repeat (10) tick();
    chk("no_dropped_word", 32'(wr_req), 32'd0);

    // Sub-burst hold, then req two edges after the 8th push; address wraps to 0.
    for (int i = 0; i < 7; i++) push(16'(i));
    repeat (10) tick();
    chk("sub_burst_hold", 32'(wr_req), 32'd0);
    push(16'h0007);
    chk("req_not_yet", 32'(wr_req), 32'd0);
    tick();
    chk("req_two_edges", 32'(wr_req), 32'd1);
    wr_burst(24'h000000, 16'h0000);

    // Write priority over read, then a separated read burst.
    init_end = 1'b0;
    for (int i = 0; i < 8; i++) push(16'h0200 + 16'(i));
    rd_allow = 1'b1;
    init_end = 1'b1;
    tick();
    chk("prio_wr_req", 32'(wr_req), 32'd1);
    chk("prio_rd_low", 32'(rd_req), 32'd0);
    wr_burst(24'h000008, 16'h0200);
    chk("gap_rd_low", 32'(rd_req), 32'd0);
    tick();
    chk("idle_wr_low", 32'(wr_req), 32'd0);
    chk("idle_rd_low", 32'(rd_req), 32'd0);
    rd_burst(24'h000000, 16'h00A0);
    chk("rd_not_empty", 32'(rd_empty), 32'd0);
    rd_burst(24'h000008, 16'h00B0);
    repeat (10) tick();
    chk("rd_stall_full", 32'(rd_req), 32'd0);
    rd_allow = 1'b0;

    // Pop all 16 words.
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_data", 32'(rd_data), (i < 8) ? 32'h00A0 + 32'(i) : 32'h00B0 + 32'(i - 8));
    end
    chk("rd_empty_after", 32'(rd_empty), 32'd1);
    tick();
    chk("rd_pop_empty", 32'(rd_valid), 32'd0);
    rd_en = 1'b0;

    // Reset during the 4th ack of a write burst.
    for (int i = 0; i < 8; i++) push(16'h0300 + 16'(i));
    tick();
    chk("rst_burst_req", 32'(wr_req), 32'd1);
    wr_ack = 1'b1;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(wr_req), 32'd0);
    chk("rst_mid_rd_addr", 32'(rd_addr), 32'd0);
    wr_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) push(16'h0400 + 16'(i));
    repeat (10) tick();
    chk("rst_fifo_cleared", 32'(wr_req), 32'd0);
    push(16'h0407);
    wr_burst(24'h000000, 16'h0400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
